// File: rtl/facpe_scan_pkg.sv
// Shared types and default sizes for the scan sequencer and its capture register.
package facpe_scan_pkg;

    localparam int SCAN_CHAIN_LEN = 64;
    localparam int SCAN_WORD_W    = 32;
    localparam int SCAN_NUM_WORDS = SCAN_CHAIN_LEN / SCAN_WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_C,
        ST_ACK,
        ST_SCAN,
        ST_DUMP,
        ST_FIN
    } state_e;

endpackage

// File: rtl/facpe_scan_capture.sv
// Capture register for the DUT scan chain plus the word-select mux used while dumping.
module facpe_scan_capture
    import facpe_scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
    parameter int WORD_W    = SCAN_WORD_W,
    parameter int IDX_W     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              shift_in,
    input  logic [IDX_W-1:0]  word_idx,
    output logic [WORD_W-1:0] word
);

    localparam int NUM_WORDS = CHAIN_LEN / WORD_W;

    logic [CHAIN_LEN-1:0]                 cap;
    logic [NUM_WORDS-1:0][WORD_W-1:0]     words;

    // Shift in at the MSB so the first bit captured ends up in bit 0 of word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cap <= '0;
        else if (shift_en)
            cap <= {shift_in, cap[CHAIN_LEN-1:1]};
    end

    assign words = cap;
    assign word  = words[word_idx];

endmodule

// File: rtl/facpe_scan_sequencer.sv
// Runs one DUT operation, then shifts out and streams the DUT scan chain.
// Build option FACPE_SCAN_RESTORE_EN recirculates sout onto sin for a non-destructive scan.
module facpe_scan_sequencer
    import facpe_scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
    parameter int WORD_W    = SCAN_WORD_W,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              skip_op,
    input  logic              scan_fill,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] snap_data,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic              val_op,
    input  logic              op_ack,
    input  logic              op_commit,
    output logic              commit_ack,
    output logic              sen,
    output logic              scan_ce,
    output logic              sin,
    input  logic              sout
);

    localparam int NUM_WORDS = CHAIN_LEN / WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    state_e              state, state_nxt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     tcnt;
    logic [IDX_W-1:0]    widx, widx_sel;
    logic [WORD_W-1:0]   cap_word;
    logic                xfer, last_word, scan_last, tmo, abort;
    logic                busy_d, done_d, err_d, val_op_d, commit_ack_d, scan_d;

    assign xfer      = snap_valid && snap_ready;
    assign last_word = (widx == IDX_W'(NUM_WORDS - 1));
    assign scan_last = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
    assign tmo       = (tcnt == TO_W'(TIMEOUT - 1));
    // A handshake arriving on the last allowed cycle still wins over the timeout.
    assign abort     = tmo && (((state == ST_REQ) && !op_ack) ||
                               ((state == ST_WAIT_C) && !op_commit));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = skip_op ? ST_SCAN : ST_REQ;
            ST_REQ:    if (op_ack) state_nxt = ST_WAIT_C;
                       else if (abort) state_nxt = ST_FIN;
            ST_WAIT_C: if (op_commit) state_nxt = ST_ACK;
                       else if (abort) state_nxt = ST_FIN;
            ST_ACK:    state_nxt = ST_SCAN;
            ST_SCAN:   if (scan_last) state_nxt = ST_DUMP;
            ST_DUMP:   if (xfer && last_word) state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state.
    always_comb begin
        val_op_d     = (state_nxt == ST_REQ);
        commit_ack_d = (state_nxt == ST_ACK);
        scan_d       = (state_nxt == ST_SCAN);
        done_d       = (state_nxt == ST_FIN);
        busy_d       = (state_nxt != ST_IDLE);
        err_d        = err;
        if ((state == ST_IDLE) && start)
            err_d = 1'b0;
        else if (abort)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_op     <= 1'b0;
            commit_ack <= 1'b0;
            sen        <= 1'b0;
            scan_ce    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            val_op     <= val_op_d;
            commit_ack <= commit_ack_d;
            sen        <= scan_d;
            scan_ce    <= scan_d;
            done       <= done_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt    <= '0;
            bit_cnt <= '0;
        end else begin
            if (state_nxt != state)
                tcnt <= '0;
            else if ((state == ST_REQ) || (state == ST_WAIT_C))
                tcnt <= tcnt + TO_W'(1);
            if (state == ST_SCAN)
                bit_cnt <= bit_cnt + BIT_W'(1);
            else
                bit_cnt <= '0;
        end
    end

`ifdef FACPE_SCAN_RESTORE_EN
    logic unused_scan_fill;
    assign unused_scan_fill = scan_fill;
    // Combinational loop-back through the DUT chain; gated so sin idles low.
    assign sin = sen & sout;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sin <= 1'b0;
        else
            sin <= scan_d ? scan_fill : 1'b0;
    end
`endif

    // First DUMP cycle only loads word 0; each transfer preloads the following word.
    assign widx_sel = xfer ? widx + IDX_W'(1) : widx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_valid <= 1'b0;
            snap_data  <= '0;
            widx       <= '0;
        end else if (state != ST_DUMP) begin
            snap_valid <= 1'b0;
            widx       <= '0;
        end else if (!snap_valid) begin
            snap_valid <= 1'b1;
            snap_data  <= cap_word;
        end else if (snap_ready) begin
            if (last_word) begin
                snap_valid <= 1'b0;
            end else begin
                snap_data <= cap_word;
                widx      <= widx_sel;
            end
        end
    end

    facpe_scan_capture #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .IDX_W     (IDX_W)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .shift_en (scan_ce),
        .shift_in (sout),
        .word_idx (widx_sel),
        .word     (cap_word)
    );

endmodule
